// File: rtl/load_store_unit.sv
// Load/store unit: one load or store per request over a req/ack data bus.
// Optional bus timeout fault enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_regwrite_o,
    output logic        resp_fault_o,
    output logic [1:0]  resp_cause_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    localparam logic [1:0] CauseMisalign = 2'd1;
    localparam logic [1:0] CauseIllegal  = 2'd2;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    logic        illegal, misaligned;
    logic [31:0] lane_wdata, ld_data;
    logic [3:0]  lane_wstrb;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    // Request decode: illegal funct3 outranks misalignment.
    always_comb begin
        if (req_is_store_i) begin
            illegal = req_funct3_i[2] | (req_funct3_i == 3'd3);
        end else begin
            illegal = (req_funct3_i == 3'd3) | (req_funct3_i == 3'd6) | (req_funct3_i == 3'd7);
        end
        misaligned = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                     ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
        lane_wdata = req_wdata_i;
        lane_wstrb = 4'b0000;
        if (req_is_store_i) begin
            case (req_funct3_i[1:0])
                2'b00: begin
                    lane_wdata = {4{req_wdata_i[7:0]}};
                    lane_wstrb = 4'b0001 << req_addr_i[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{req_wdata_i[15:0]}};
                    lane_wstrb = req_addr_i[1] ? 4'b1100 : 4'b0011;
                end
                default: lane_wstrb = 4'b1111;
            endcase
        end
    end

    // Load lane extraction from the acked word.
    always_comb begin
        ld_half = 16'(mem_rdata_i >> {addr_q[1:0], 3'b000});
        ld_byte = ld_half[7:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    is_store_d = req_is_store_i;
                    funct3_d   = req_funct3_i;
                    addr_d     = req_addr_i;
                    wdata_d    = lane_wdata;
                    wstrb_d    = lane_wstrb;
                    rd_d       = req_rd_i;
                    rdata_d    = 32'd0;
                    fault_d    = illegal | misaligned;
                    cause_d    = illegal ? CauseIllegal : (misaligned ? CauseMisalign : 2'd0);
                    state_d    = (illegal | misaligned) ? StResp : StBus;
`ifdef LSU_TIMEOUT_EN
                    cnt_d      = 16'd0;
`endif
                end
            end
            StBus: begin
                if (mem_ack_i) begin
                    if (!is_store_q) begin
                        rdata_d = ld_data;
                    end
                    state_d = StResp;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    fault_d = 1'b1;
                    cause_d = 2'd3;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            rd_q       <= 5'd0;
            rdata_q    <= 32'd0;
            fault_q    <= 1'b0;
            cause_q    <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        req_ready_o     = (state_q == StIdle);
        mem_req_o       = (state_q == StBus);
        mem_we_o        = (state_q == StBus) & is_store_q;
        mem_wstrb_o     = (state_q == StBus) ? wstrb_q : 4'b0000;
        mem_addr_o      = {addr_q[31:2], 2'b00};
        mem_wdata_o     = wdata_q;
        resp_valid_o    = (state_q == StResp);
        resp_rdata_o    = resp_valid_o ? rdata_q : 32'd0;
        resp_rd_o       = resp_valid_o ? rd_q : 5'd0;
        resp_fault_o    = resp_valid_o & fault_q;
        resp_cause_o    = resp_valid_o ? cause_q : 2'd0;
        resp_regwrite_o = resp_valid_o & ~is_store_q & ~fault_q & (rd_q != 5'd0);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the riscv_processor datapath.
- Takes the ALU result as the effective address and the rs2 value as store data, and runs one load or store per request over a simple req/ack data-memory bus.
- Produces an aligned, sign/zero-extended writeback value with rd tag, and flags faults (misaligned, illegal funct3, optional bus timeout).
- Multi-cycle FSM; one transaction in flight.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUS without mem_ack before a timeout fault (only used when LSU_TIMEOUT_EN is defined); legal range 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_is_store  in  1  1=store (SB/SH/SW), 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2 value)
- req_rd  in  5  load destination register
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes (0000 on loads)
- mem_ack  in  1  bus completion, sampled while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/faults)
- resp_rd  out  5  rd tag of the completed request
- resp_regwrite  out  1  write back to register file
- resp_fault  out  1  transaction faulted
- resp_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout

Behaviour:
- Reset values: state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0; all resp_* outputs 0.
- States:
  - IDLE: req_ready=1. On req_valid, capture all request fields.
    - If a fault is detected, go to RESP.
    - Otherwise go to BUS.
  - BUS: mem_req=1 with stable addr/we/wdata/wstrb. When mem_ack=1, capture mem_rdata and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 here, so back-to-back requests are spaced by at least one cycle.
- Latency: request accepted at edge N; mem_req high in cycle N+1. With mem_ack in N+1, resp_valid is high in N+2. Faulted requests give resp_valid in N+1 with no bus activity.
- Illegal funct3 (cause 2): loads 3,6,7; stores 3..7. Takes priority over misaligned.
- Misaligned (cause 1):
  - half (funct3[1:0]=01) with addr[0]=1
  - word (10) with addr[1:0]!=00
  - byte never misaligned
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 0011 or 1100 per addr[1]; half replicated ×2.
  - SW: wstrb = 1111.
- Load extract, selecting the lane by addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- resp_regwrite = load & ~fault & (rd!=0). Stores and faults never write back.
- mem_ack outside BUS is ignored. mem_rdata is sampled only on ack.
- Reset mid-transaction: the next edge returns to IDLE with mem_req=0. The abandoned request produces no resp_valid.
- req_valid during BUS or RESP is not accepted; the upstream stage must hold it.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, mem_req drops and the FSM goes to RESP with resp_fault=1, cause=3. An ack in the same cycle as the timeout wins (normal completion).
- Undefined: BUS waits indefinitely, no counter logic, cause 3 never produced.

Test Plan:
- LW, addr 0x100, rd=5, mem_rdata=0xDEADBEEF, ack on first BUS cycle:
  - mem_addr=0x100, wstrb=0000.
  - resp_valid two cycles after accept; rdata=0xDEADBEEF, rd=5, regwrite=1.
- LB and LBU, addr 0x103, mem_rdata=0x80FF_0000:
  - LB gives rdata=0xFFFFFF80.
  - LBU gives 0x00000080.
  - LH at 0x102 gives 0xFFFF80FF.
- SB, addr 0x201, wdata 0x123456AB:
  - mem_we=1, mem_addr=0x200, wstrb=0010, wdata=0xABABABAB.
  - resp regwrite=0, fault=0.
- LW at 0x102 and SH at 0x101:
  - no mem_req; resp_valid next cycle with fault=1, cause=1, regwrite=0.
  - Load funct3=7 gives cause=2.
- ack delayed 4 cycles, then reset asserted during BUS:
  - mem_req held stable until ack.
  - Under reset, mem_req=0 after the edge, no resp_valid; a new request then completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never asserted:
  - mem_req high for 8 cycles, then resp_fault=1, cause=3.
  - Without the macro, still waiting after 300 cycles.
